// File: rtl/emmc_blk_buf.sv
// emmc_blk_buf
//   Single-block byte buffer that sits between a user byte stream and the
//   emmc_sm command engine.
//
//   Write path: a block of BLK_BYTES bytes is collected over the wr_* valid/
//   ready port, an eMMC write is started, and the stored bytes are presented
//   on sm_dat_o one per sm_dvalid_i pulse.
//   Read path: rd_req_i starts an eMMC read, the returned bytes are captured
//   on sm_dvalid_i, and the full block is streamed out on the rd_* port.
//   Each transfer is guarded by a short-transfer check, an over-run check and
//   an inactivity timeout; any of these latch err_o until err_clr_i.
//
// Ports
//   clk_i        sole clock
//   arst_i       asynchronous active-high reset
//   wr_valid_i   user write byte valid
//   wr_data_i    user write byte
//   wr_ready_o   buffer accepts a write byte
//   rd_req_i     request one block read
//   rd_valid_o   read byte valid
//   rd_data_o    read byte
//   rd_last_o    marks the final byte of the read block
//   rd_ready_i   user accepts the read byte
//   busy_o       buffer is not idle
//   err_o        error latched
//   err_clr_i    clears the error and returns to idle
//   sm_we_o      emmc_sm we_i
//   sm_start_o   emmc_sm start_i
//   sm_dat_o     emmc_sm dat_i
//   sm_dat_i     emmc_sm dat_o
//   sm_dvalid_i  emmc_sm dvalid_o
//   sm_ready_i   emmc_sm ready_o
module emmc_blk_buf #(
    parameter int BLK_BYTES    = 512,
    parameter int XFER_TIMEOUT = 65535
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       wr_valid_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_ready_o,
    input  logic       rd_req_i,
    output logic       rd_valid_o,
    output logic [7:0] rd_data_o,
    output logic       rd_last_o,
    input  logic       rd_ready_i,
    output logic       busy_o,
    output logic       err_o,
    input  logic       err_clr_i,
    output logic       sm_we_o,
    output logic       sm_start_o,
    output logic [7:0] sm_dat_o,
    input  logic [7:0] sm_dat_i,
    input  logic       sm_dvalid_i,
    input  logic       sm_ready_i
);

    // One extra pointer bit so that "all BLK_BYTES transferred" is a
    // representable value distinct from every valid byte index.
    localparam int PTR_W = $clog2(BLK_BYTES) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam int TMO_W = $clog2(XFER_TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(BLK_BYTES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BLK_BYTES - 1);
    // ERR is entered on the edge at which the idle count reaches
    // XFER_TIMEOUT, i.e. XFER_TIMEOUT cycles after the last data strobe.
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(XFER_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_W_START = 3'd2;
    localparam logic [2:0] S_W_XFER  = 3'd3;
    localparam logic [2:0] S_R_START = 3'd4;
    localparam logic [2:0] S_R_XFER  = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    // Set during the first cycle of a transfer phase; sm_ready_i is still
    // high from the start handshake there and must not count as completion.
    logic             first_q, first_d;

    logic [7:0]       mem_q [BLK_BYTES];
    logic             mem_we;
    logic [7:0]       mem_wdata;
    logic [IDX_W-1:0] idx;

    // When ptr == BLK_BYTES the index wraps; the read value is unused then.
    assign idx       = ptr_q[IDX_W-1:0];
    assign rd_data_o = mem_q[idx];
    assign sm_dat_o  = mem_q[idx];
    assign busy_o    = (state_q != S_IDLE);
    assign err_o     = (state_q == S_ERR);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tmo_d      = tmo_q;
        first_d    = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = wr_data_i;
        wr_ready_o = 1'b0;
        rd_valid_o = 1'b0;
        rd_last_o  = 1'b0;
        sm_we_o    = 1'b0;
        sm_start_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A read request takes priority over a write byte.
                wr_ready_o = !rd_req_i;
                if (rd_req_i) begin
                    state_d = S_R_START;
                    ptr_d   = '0;
                end else if (wr_valid_i) begin
                    mem_we  = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    mem_we = 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = '0;
                        state_d = S_W_START;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            S_W_START: begin
                sm_we_o    = 1'b1;
                sm_start_o = sm_ready_i;
                if (sm_ready_i) begin
                    state_d = S_W_XFER;
                    first_d = 1'b1;
                end
            end

            S_R_START: begin
                sm_start_o = sm_ready_i;
                if (sm_ready_i) begin
                    state_d = S_R_XFER;
                    first_d = 1'b1;
                end
            end

            S_W_XFER, S_R_XFER: begin
                sm_we_o = (state_q == S_W_XFER);
                if (sm_dvalid_i && (ptr_q == PTR_FULL)) begin
                    // Engine delivered more strobes than the block holds.
                    state_d = S_ERR;
                end else if (sm_ready_i && !first_q) begin
                    if (ptr_q == PTR_FULL) begin
                        state_d = (state_q == S_W_XFER) ? S_IDLE : S_DRAIN;
                        ptr_d   = '0;
                    end else begin
                        // Engine finished before the whole block moved.
                        state_d = S_ERR;
                    end
                end else if (sm_dvalid_i) begin
                    ptr_d = ptr_q + 1'b1;
                    tmo_d = '0;
                    if (state_q == S_R_XFER) begin
                        mem_we    = 1'b1;
                        mem_wdata = sm_dat_i;
                    end
                end else if (tmo_q == TMO_LIM) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DRAIN: begin
                rd_valid_o = 1'b1;
                rd_last_o  = (ptr_q == PTR_LAST);
                if (rd_ready_i) begin
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            S_ERR: begin
                if (err_clr_i) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase

        // The idle counter restarts whenever a new state is entered.
        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            tmo_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            first_q <= first_d;
        end
    end

    // Block storage carries no reset so it can map onto a RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_emmc_blk_buf.sv
module tb_emmc_blk_buf;

    localparam int BLK = 512;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       arst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_ready;
    logic       busy;
    logic       err;
    logic       err_clr;
    logic       sm_we;
    logic       sm_start;
    logic [7:0] sm_dat_out;
    logic [7:0] sm_dat_in;
    logic       sm_dvalid;
    logic       sm_ready;

    int nchk = 0;
    int nerr = 0;

    // Reference model: the block the user wrote and the block the card returns.
    logic [7:0] wblk [BLK];
    logic [7:0] rblk [BLK];

    always #5 clk = ~clk;

    emmc_blk_buf #(
        .BLK_BYTES   (BLK),
        .XFER_TIMEOUT(TO)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .rd_req_i   (rd_req),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_last_o  (rd_last),
        .rd_ready_i (rd_ready),
        .busy_o     (busy),
        .err_o      (err),
        .err_clr_i  (err_clr),
        .sm_we_o    (sm_we),
        .sm_start_o (sm_start),
        .sm_dat_o   (sm_dat_out),
        .sm_dat_i   (sm_dat_in),
        .sm_dvalid_i(sm_dvalid),
        .sm_ready_i (sm_ready)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        rd_req    = 1'b0;
        rd_ready  = 1'b0;
        err_clr   = 1'b0;
        sm_dvalid = 1'b0;
        sm_dat_in = 8'h00;
        sm_ready  = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        arst = 1'b1;
        idle_inputs();
        tick();
        tick();
        obs = {wr_ready, rd_valid, rd_last, busy, err, sm_start, sm_we};
        nchk++;
        if (obs !== 7'b1000000) begin
            nerr++;
            $display("FAIL reset_during: outputs=%b expected=%b", obs, 7'b1000000);
        end
        arst = 1'b0;
        tick();
        obs = {wr_ready, rd_valid, rd_last, busy, err, sm_start, sm_we};
        nchk++;
        if (obs !== 7'b1000000) begin
            nerr++;
            $display("FAIL reset_after: outputs=%b expected=%b", obs, 7'b1000000);
        end
    endtask

    // Push one block; pattern 0 gives 0x00..0xFF twice, otherwise random.
    // rdreq_at raises rd_req_i together with that byte (ignored in FILL).
    task automatic fill_block(input int pattern, input int rdreq_at);
        logic [2:0] obs;
        for (int i = 0; i < BLK; i++) begin
            wblk[i] = (pattern == 0) ? 8'(i) : 8'($urandom);
        end
        for (int i = 0; i < BLK; i++) begin
            repeat ($urandom_range(0, 1)) begin
                wr_valid = 1'b0;
                rd_req   = 1'b0;
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = wblk[i];
            rd_req   = (i == rdreq_at);
            #1;
            nchk++;
            if (wr_ready !== 1'b1) begin
                nerr++;
                $display("FAIL fill_ready: byte %0d wr_ready=%b expected=1", i, wr_ready);
            end
            tick();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        #1;
        obs = {wr_ready, busy, sm_we};
        nchk++;
        if (obs !== 3'b011) begin
            nerr++;
            $display("FAIL fill_done: {wr_ready,busy,sm_we}=%b expected=011", obs);
        end
    endtask

    task automatic start_write(input int wait_cycles);
        for (int k = 0; k < wait_cycles; k++) begin
            sm_ready = 1'b0;
            #1;
            nchk++;
            if ({sm_start, busy} !== 2'b01) begin
                nerr++;
                $display("FAIL start_gate: cycle %0d {sm_start,busy}=%b expected=01", k, {sm_start, busy});
            end
            tick();
        end
        sm_ready = 1'b1;
        #1;
        nchk++;
        if ({sm_start, sm_we} !== 2'b11) begin
            nerr++;
            $display("FAIL start_write: {sm_start,sm_we}=%b expected=11", {sm_start, sm_we});
        end
        tick();
        sm_ready = 1'b0;
        #1;
        nchk++;
        if ({sm_start, sm_we} !== 2'b01) begin
            nerr++;
            $display("FAIL start_single: {sm_start,sm_we}=%b expected=01", {sm_start, sm_we});
        end
    endtask

    // Engine model for a write: pulses sm_dvalid_i nbytes times with gaps.
    task automatic xfer_write(input int nbytes);
        sm_ready = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(0, 3)) begin
                sm_dvalid = 1'b0;
                tick();
            end
            sm_dvalid = 1'b1;
            #1;
            if (i < BLK) begin
                nchk++;
                if (sm_dat_out !== wblk[i]) begin
                    nerr++;
                    $display("FAIL wr_data: byte %0d sm_dat=%h expected=%h", i, sm_dat_out, wblk[i]);
                end
            end
            tick();
        end
        sm_dvalid = 1'b0;
    endtask

    task automatic finish_write();
        sm_ready = 1'b1;
        tick();
        nchk++;
        if ({busy, wr_ready, err, sm_we} !== 4'b0100) begin
            nerr++;
            $display("FAIL wr_done: {busy,wr_ready,err,sm_we}=%b expected=0100", {busy, wr_ready, err, sm_we});
        end
    endtask

    task automatic clear_error(input string name);
        nchk++;
        if ({err, busy, wr_ready, sm_start} !== 4'b1100) begin
            nerr++;
            $display("FAIL %s_err: {err,busy,wr_ready,sm_start}=%b expected=1100", name, {err, busy, wr_ready, sm_start});
        end
        sm_ready = 1'b1;
        err_clr  = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        nchk++;
        if ({err, busy, wr_ready} !== 3'b001) begin
            nerr++;
            $display("FAIL %s_clr: {err,busy,wr_ready}=%b expected=001", name, {err, busy, wr_ready});
        end
    endtask

    task automatic start_read(input bit with_wr);
        sm_ready = 1'b1;
        rd_req   = 1'b1;
        wr_valid = with_wr;
        wr_data  = 8'h5A;
        #1;
        nchk++;
        if (wr_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rd_arb: wr_ready=%b expected=0", wr_ready);
        end
        tick();
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        #1;
        nchk++;
        if ({busy, sm_start, sm_we} !== 3'b110) begin
            nerr++;
            $display("FAIL rd_start: {busy,sm_start,sm_we}=%b expected=110", {busy, sm_start, sm_we});
        end
        tick();
    endtask

    // Engine model for a read returning nbytes of rblk, then the user drain.
    task automatic xfer_read(input int nbytes);
        int k;
        int cyc;
        sm_ready = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(0, 3)) begin
                sm_dvalid = 1'b0;
                tick();
            end
            sm_dvalid = 1'b1;
            sm_dat_in = rblk[i];
            tick();
        end
        sm_dvalid = 1'b0;
        sm_ready  = 1'b1;
        tick();
        if (nbytes != BLK) begin
            clear_error("short");
        end else begin
            k   = 0;
            cyc = 0;
            while (k < BLK && cyc < 5000) begin
                rd_ready = ($urandom_range(0, 3) != 0);
                #1;
                nchk++;
                if ({rd_valid, rd_last, rd_data} !== {1'b1, (k == BLK - 1), rblk[k]}) begin
                    nerr++;
                    $display("FAIL rd_out: byte %0d {valid,last,data}=%b/%b/%h expected=1/%b/%h",
                             k, rd_valid, rd_last, rd_data, (k == BLK - 1), rblk[k]);
                end
                if (rd_ready) k++;
                tick();
                cyc++;
            end
            rd_ready = 1'b0;
            nchk++;
            if (k != BLK) begin
                nerr++;
                $display("FAIL rd_drain_timeout: drained=%0d expected=%0d", k, BLK);
            end
            #1;
            nchk++;
            if ({busy, rd_valid, rd_last} !== 3'b000) begin
                nerr++;
                $display("FAIL rd_done: {busy,rd_valid,rd_last}=%b expected=000", {busy, rd_valid, rd_last});
            end
        end
    endtask

    task automatic test_write_block();
        fill_block(0, -1);
        start_write(0);
        xfer_write(BLK);
        finish_write();
    endtask

    task automatic test_read_block();
        for (int i = 0; i < BLK; i++) rblk[i] = 8'(i) ^ 8'hA5;
        start_read(1'b0);
        xfer_read(BLK);
    endtask

    task automatic test_start_gating();
        fill_block(1, -1);
        start_write(20);
        xfer_write(BLK);
        finish_write();
    endtask

    task automatic test_fill_rdreq();
        fill_block(1, 5);
        start_write(0);
        xfer_write(BLK);
        finish_write();
    endtask

    task automatic test_arbitration_read();
        for (int i = 0; i < BLK; i++) rblk[i] = 8'($urandom);
        start_read(1'b1);
        xfer_read(BLK);
    endtask

    task automatic test_short_read();
        for (int i = 0; i < BLK; i++) rblk[i] = 8'($urandom);
        start_read(1'b0);
        xfer_read(300);
    endtask

    task automatic test_timeout();
        fill_block(1, -1);
        start_write(0);
        xfer_write(10);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) begin
                nchk++;
                if (err !== 1'b0) begin
                    nerr++;
                    $display("FAIL tmo_early: err=%b after %0d idle cycles expected=0", err, k);
                end
            end
        end
        clear_error("timeout");
    endtask

    task automatic test_overrun();
        fill_block(1, -1);
        start_write(0);
        xfer_write(BLK + 1);
        clear_error("overrun");
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs;
        fill_block(1, -1);
        start_write(0);
        xfer_write(50);
        arst = 1'b1;
        #1;
        obs = {wr_ready, rd_valid, rd_last, busy, err, sm_start, sm_we};
        nchk++;
        if (obs !== 7'b1000000) begin
            nerr++;
            $display("FAIL reset_mid: outputs=%b expected=%b", obs, 7'b1000000);
        end
        tick();
        arst     = 1'b0;
        sm_ready = 1'b1;
        tick();
        fill_block(1, -1);
        start_write(0);
        xfer_write(BLK);
        finish_write();
    endtask

    initial begin
        test_reset();
        test_write_block();
        test_read_block();
        test_start_gating();
        test_fill_rdreq();
        test_arbitration_read();
        test_short_read();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
